// File: rtl/wb_pkg.sv
// Shared write-back definitions: register-file geometry and the requester payload.
package wb_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int XLEN_DEF   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN_DEF-1:0]   data;
   } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from last+1, pointer moves on advance.
module rr_arbiter #(
   parameter  int NUM_REQ = 3,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] valid,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx
);
   logic [IDX_W-1:0] last;
   logic             found;
   int               idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      // i runs 1..NUM_REQ so the previous winner is checked last
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = (int'(last) + i) % NUM_REQ;
         if (!found && valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last <= IDX_W'(NUM_REQ - 1);
      else if (advance) last <= grant_idx;
   end
endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-bank write-port arbiter with registered output stage and a
// pending-write scoreboard for read-after-write stalls.
module regfile_wb_ctrl
   import wb_pkg::*;
#(
   parameter  int NUM_REQ = 3,
   parameter  int XLEN    = XLEN_DEF,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_i,
   input  logic [NUM_REQ*XLEN-1:0]       req_data_i,
   output logic                          wr_en_o,
   output logic [REG_ADDR_W-1:0]         RD_ADDR_o,
   output logic [XLEN-1:0]               data_o,
   input  logic                          issue_en_i,
   input  logic [REG_ADDR_W-1:0]         issue_rd_i,
   input  logic                          flush_i,
   input  logic [REG_ADDR_W-1:0]         RS1_ADDR_i,
   input  logic [REG_ADDR_W-1:0]         RS2_ADDR_i,
   output logic                          RS1_busy_o,
   output logic                          RS2_busy_o
);
   logic [NUM_REQ-1:0][REG_ADDR_W-1:0] rd_arr;
   logic [NUM_REQ-1:0][XLEN-1:0]       data_arr;
   logic [NUM_REQ-1:0]                 grant;
   logic [IDX_W-1:0]                   grant_idx;
   logic                               xfer;
   logic [REG_ADDR_W-1:0]              sel_rd;
   logic [XLEN-1:0]                    sel_data;
   logic [NUM_REGS-1:0]                busy, busy_nxt;

   assign rd_arr   = req_rd_i;
   assign data_arr = req_data_i;
   assign xfer     = |(req_valid_i & grant);
   assign sel_rd   = rd_arr[grant_idx];
   assign sel_data = data_arr[grant_idx];

   assign req_ready_o = grant;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid     (req_valid_i),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // x0 transfers are accepted but never reach the bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_o   <= 1'b0;
         RD_ADDR_o <= '0;
         data_o    <= '0;
      end else if (xfer) begin
         wr_en_o   <= (sel_rd != '0);
         RD_ADDR_o <= sel_rd;
         data_o    <= sel_data;
      end else begin
         wr_en_o   <= 1'b0;
      end
   end

   // Clear on the edge the bank commits; a same-cycle issue re-sets afterwards
   always_comb begin
      busy_nxt = busy;
      if (flush_i)      busy_nxt = '0;
      else if (wr_en_o) busy_nxt[RD_ADDR_o] = 1'b0;
      if (issue_en_i && issue_rd_i != '0) busy_nxt[issue_rd_i] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy <= '0;
      else        busy <= busy_nxt;
   end

   assign RS1_busy_o = busy[RS1_ADDR_i];
   assign RS2_busy_o = busy[RS2_ADDR_i];
endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 32 x 32-bit register bank: it shares the bank's single write port between NUM_REQ write-back requesters using round-robin arbitration and a registered output stage. It also keeps a per-register pending-write scoreboard so the issue stage can stall on read-after-write hazards. It sits between the execution units (ALU, load unit, CSR unit) and the `wr_en_i/RD_ADDR_i/data_i` port of the register bank.

## Interface
- `NUM_REQ`, 3: number of write-back requesters (2..8).
- `XLEN`, 32: data width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid_i` in NUM_REQ: requester k has a write-back pending.
- `req_ready_o` out NUM_REQ: requester k is granted this cycle; transfer when valid&ready.
- `req_rd_i` in NUM_REQ*5: destination register per requester; slice k = bits [5k+4:5k].
- `req_data_i` in NUM_REQ*XLEN: write data per requester.
- `wr_en_o` out 1: drives the register bank write enable.
- `RD_ADDR_o` out 5: drives the register bank write address.
- `data_o` out XLEN: drives the register bank write data.
- `issue_en_i` in 1: an instruction writing `issue_rd_i` is issued this cycle.
- `issue_rd_i` in 5: destination of the issued instruction.
- `flush_i` in 1: clear all pending bits (pipeline flush).
- `RS1_ADDR_i`, `RS2_ADDR_i` in 5: source registers of the instruction in decode.
- `RS1_busy_o`, `RS2_busy_o` out 1: source has a pending write; issue stage must stall.

## Operation
- Arbitration: round-robin with pointer `last`. Search starts at requester `(last+1) mod NUM_REQ` and grants the first requester with valid set. At most one `req_ready_o` bit is high per cycle. It is combinational from `req_valid_i` and `last`. On a transfer, `last` is set to the granted index.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is illegal.
- Output stage: on a transfer, the payload is registered.
  - If the granted rd is non-zero: `wr_en_o`=1, `RD_ADDR_o`=rd, `data_o`=data.
  - If the granted rd is x0: the transfer is accepted (ready is high), but `wr_en_o`=0 next cycle.
  - With no transfer, `wr_en_o`=0 next cycle, and `RD_ADDR_o`/`data_o` hold their previous values.
- Scoreboard: a 32-bit `busy` vector. Bit 0 is constantly 0.
  - Set: `issue_en_i` with `issue_rd_i`≠0 sets `busy[issue_rd_i]`.
  - Clear: in a cycle where `wr_en_o`=1, `busy[RD_ADDR_o]` clears at the closing edge. That is the same edge at which the bank performs the write.
  - The same register set and cleared in one cycle: set wins.
  - `flush_i` clears all bits. If `issue_en_i` is also high, the issued register is set anyway.
- `RSn_busy_o` = `busy[RSn_ADDR_i]`, combinational. `RSn_busy_o` is 0 for address 0.

## Timing
- Reset values:
  - `wr_en_o`=0, `RD_ADDR_o`=0, `data_o`=0.
  - `busy`=0, so both busy outputs are 0.
  - `last`=NUM_REQ-1, so requester 0 has first priority.
- Latency, requester to bank: the transfer in cycle T gives `wr_en_o` in cycle T+1, and the bank is updated at the end of T+1.
- Latency, busy release: busy clears at the end of T+1, so a dependent reader sees busy=0 and valid bank data in cycle T+2.
- Throughput: one write-back per cycle, sustained.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately. A write-back registered but not yet committed is lost. Requesters must re-present after reset.

## Structure
- Shared package `wb_pkg`: `REG_ADDR_W`=5, `NUM_REGS`=32, `XLEN` default, and a `wb_req_t` struct (rd, data) for future requester ports.
- Sub-module `rr_arbiter`, parameterised by `NUM_REQ`. It takes valid in and produces a one-hot grant out, with the pointer updated on `advance`. The parameter and pointer rules are as in Operation.
- The output register and scoreboard stay in `regfile_wb_ctrl`.

## Test plan
- **Reset and single write:** release reset; req0 valid with rd=5, data=0xDEADBEEF. Required: ready0 the same cycle; next cycle `wr_en_o`=1, `RD_ADDR_o`=5, `data_o`=0xDEADBEEF. All other cycles `wr_en_o`=0.
- **Round-robin:** all three requesters held valid (rd=1,2,3) for 6 cycles. Required: grants in order 0,1,2,0,1,2, and `wr_en_o` high on 6 consecutive cycles.
- **x0 drop:** req1 valid with rd=0, data=0x1234. Required: ready1=1; next cycle `wr_en_o`=0; `busy` unchanged.
- **Scoreboard:**
  - Issue rd=7 in cycle 0, then `RS1_ADDR_i`=7 gives `RS1_busy_o`=1.
  - req2 transfers rd=7 in cycle 4: `wr_en_o` in cycle 5, and `RS1_busy_o`=0 from cycle 6.
  - Issue rd=7 in cycle 5 (same cycle as the clear): busy stays 1.
- **Flush:**
  - Busy set for x3 and x9; `flush_i` with `issue_en_i` rd=9. Required next cycle: busy[3]=0, busy[9]=1.
- **Async reset mid-transfer:** assert `rst_n`=0 while `wr_en_o`=1. Required:
  - `wr_en_o`, `RD_ADDR_o`, `data_o` go to 0 and all busy bits clear, without waiting for a clock edge.
  - After release, requester 0 is granted first.
